// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, 8N1 frame constants, bit timing.
// Latency: none (package only).
// Backpressure: none (package only).
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

  // 8N1 frame: 8 data bits LSB first, no parity, one stop bit, line idles high
  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_STOP_BITS  = 1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Bit timing in system-clock cycles: full bit period and half period
  typedef struct packed {
    int div;
    int half;
  } uart_timing_t;

  // Integer division on purpose: the residual error stays well inside the baud tolerance
  function automatic uart_timing_t uart_timing(input int clk_hz, input int baud_hz);
    uart_timing_t t;
    t.div  = clk_hz / baud_hz;
    t.half = t.div / 2;
    return t;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages reset to RST_VAL so no false edge appears at release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centred bit sampling and a one-entry valid/ready holding register.
// Latency: byte/error flags registered on the stop-sample edge, T0+HALF+9*DIV.
// Backpressure: one held byte; a byte completing while full and not accepted is dropped with an overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_CLK_HZ        = 40000000,
  parameter int UART_SCLK_HZ       = 115200,
  parameter int UART_COUNTER_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      uart_rxd,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam uart_timing_t TIMING = uart_timing(UART_CLK_HZ, UART_SCLK_HZ);
  localparam int CW   = UART_COUNTER_WIDTH;
  localparam int DIV  = TIMING.div;
  localparam int HALF = TIMING.half;

  generate
    if ((DIV - 1) >= (1 << CW) || HALF < 1) begin : g_bad_timing
      $error("uart_rx: DIV-1 does not fit in UART_COUNTER_WIDTH or baud too high for clock");
    end
  endgenerate

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rxd_s;
  uart_state_t               state, state_nxt;
  logic [CW-1:0]             timer, timer_nxt;
  logic [2:0]                idx, idx_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic                      deliver;
  logic                      stop_bad;
  logic                      timer_zero;

  sync_2ff #(
    .RST_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (uart_rxd),
    .q       (rxd_s)
  );

  assign timer_zero = (timer == '0);

  // Frame FSM next state: timer counts down to each centred sample point
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    deliver   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxd_s) begin
          timer_nxt = HALF_M1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (!timer_zero) begin
          timer_nxt = timer - CW'(1);
        end else if (!rxd_s) begin
          timer_nxt = DIV_M1;
          idx_nxt   = 3'd0;
          state_nxt = ST_DATA;
        end else begin
          // start bit gone by mid-bit: treat as a glitch
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!timer_zero) begin
          timer_nxt = timer - CW'(1);
        end else begin
          shreg_nxt[idx] = rxd_s;
          timer_nxt      = DIV_M1;
          idx_nxt        = idx + 3'd1;
          if (idx == IDX_LAST) begin
            state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (!timer_zero) begin
          timer_nxt = timer - CW'(1);
        end else if (rxd_s) begin
          deliver   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stop_bad  = 1'b1;
          state_nxt = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        // a held-low line (break) must not look like a fresh start bit
        if (rxd_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM, bit timer, bit index and shift register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= 3'd0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Holding register and one-cycle error pulses, all updated on the stop-sample edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: whole line/ready/reset waveform is built up front,
// a sample-point model derives the expected outputs for every cycle, then the DUT is
// compared against it each cycle plus a set of hand-computed literal points.
module tb_uart_rx;

  localparam int CLK_HZ = 40000000;
  localparam int BAUD   = 115200;
  localparam int CW     = 9;
  localparam int DIV    = CLK_HZ / BAUD;   // 347
  localparam int HALF   = DIV / 2;         // 173
  localparam int STOPO  = HALF + 9 * DIV;  // 3296
  localparam int NMAX   = 90000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rxd;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .UART_CLK_HZ        (CLK_HZ),
    .UART_SCLK_HZ       (BAUD),
    .UART_COUNTER_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rxd  (uart_rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Per-edge stimulus (value present at edge e) and per-edge expected outputs after edge e
  bit          pin [NMAX];
  bit          rdy [NMAX];
  bit          rst [NMAX];
  bit          dlv [NMAX];
  bit          fev [NMAX];
  logic [7:0]  dby [NMAX];
  logic [10:0] expo[NMAX];   // {valid, data, frame_err, overrun}

  int wp;
  int ncyc;
  int checks;
  int errors;

  typedef struct {
    int    e;
    int    fld;   // 0 valid, 1 data, 2 frame_err, 3 overrun
    int    val;
    string name;
  } lit_t;
  lit_t lits[$];

  function automatic void add_lit(input int e, input int fld, input int val, input string name);
    lit_t l;
    l.e = e; l.fld = fld; l.val = val; l.name = name;
    lits.push_back(l);
  endfunction

  // rmode: 0 ready low, 1 ready high, 2 ready random
  task automatic put(input bit v, input int n, input int rmode);
    for (int i = 0; i < n; i++) begin
      if (wp < NMAX) begin
        pin[wp] = v;
        rdy[wp] = (rmode == 2) ? ($urandom_range(0, 2) == 0) : (rmode == 1);
        wp++;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bl, input int stop_low,
                            input int rmode, output int fall);
    fall = wp;
    put(1'b0, bl, rmode);
    for (int k = 0; k < 8; k++) put(b[k], bl, rmode);
    if (stop_low > 0) put(1'b0, stop_low, rmode);
    put(1'b1, bl, rmode);
  endtask

  // Line level the receiver sees at edge t: pin two edges earlier, forced high by reset
  function automatic bit sv(input int t);
    if (t < 2) return 1'b1;
    if (rst[t-1] || rst[t-2]) return 1'b1;
    return pin[t-2];
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int i = a; i <= b && i < ncyc; i++) if (rst[i]) return i;
    return -1;
  endfunction

  // Model: find start edges, read the line at the nominal sample instants, then run the holding register
  task automatic build_model();
    int t, t0, hs, se, r;
    logic [7:0] b;
    bit hv, fe, ov;
    logic [7:0] hd;
    t = 0;
    while (t < ncyc) begin
      if (rst[t] || sv(t)) begin t++; continue; end
      t0 = t; hs = t0 + HALF; se = t0 + STOPO;
      r = first_rst(t0 + 1, hs);
      if (r >= 0) begin t = r; continue; end
      if (hs >= ncyc) break;
      if (sv(hs)) begin t = hs + 1; continue; end
      r = first_rst(hs + 1, se);
      if (r >= 0) begin t = r; continue; end
      if (se >= ncyc) break;
      for (int k = 0; k < 8; k++) b[k] = sv(t0 + HALF + (k + 1) * DIV);
      if (sv(se)) begin
        dlv[se] = 1'b1; dby[se] = b; t = se + 1;
      end else begin
        fev[se] = 1'b1; t = se + 1;
        while (t < ncyc && !rst[t] && !sv(t)) t++;
        if (t < ncyc && !rst[t]) t++;
      end
    end
    hv = 1'b0; hd = 8'h00;
    for (int i = 0; i < ncyc; i++) begin
      if (rst[i]) begin
        hv = 1'b0; hd = 8'h00; fe = 1'b0; ov = 1'b0;
      end else begin
        fe = fev[i]; ov = 1'b0;
        if (dlv[i]) begin
          if (!hv || rdy[i]) begin hd = dby[i]; hv = 1'b1; end
          else ov = 1'b1;
        end else if (hv && rdy[i]) begin
          hv = 1'b0;
        end
      end
      expo[i] = {hv, hd, fe, ov};
    end
  endtask

  initial begin
    int fa, fg, fc, f11, f22, f00, fff, f55, f99, ff0, f3c, fr, rp0, rp1, rpos;
    logic [10:0] got;
    int gv;
    logic [7:0] rb;
    int bl, sl;

    reset_n  = 1'b0;
    uart_rxd = 1'b1;
    ready    = 1'b0;
    checks   = 0;
    errors   = 0;
    wp       = 0;

    // Directed scenarios
    put(1'b1, 4, 0);
    for (int i = 0; i < 4; i++) rst[i] = 1'b1;
    put(1'b1, 30, 0);
    send_frame(8'hA5, DIV, 0, 0, fa);
    put(1'b1, 40, 0); rp0 = wp; put(1'b1, 1, 1); put(1'b1, 40, 0);
    fg = wp; put(1'b0, 100, 0); put(1'b1, 400, 0);
    send_frame(8'h00, DIV, 2 * DIV, 0, fc); put(1'b1, 100, 0);
    send_frame(8'h11, DIV, 0, 0, f11);
    send_frame(8'h22, DIV, 0, 0, f22);
    put(1'b1, 60, 0); rp1 = wp; put(1'b1, 1, 1); put(1'b1, 60, 0);
    send_frame(8'h00, DIV, 0, 1, f00);
    send_frame(8'hFF, DIV, 0, 1, fff);
    send_frame(8'h55, DIV, 0, 1, f55);
    put(1'b1, 60, 1);
    send_frame(8'h99, DIV, 0, 0, f99); put(1'b1, 60, 0);
    send_frame(8'hF0, DIV, 0, 0, ff0);
    rpos = ff0 + 5 * DIV + HALF;
    for (int i = 0; i < 3; i++) rst[rpos + i] = 1'b1;
    put(1'b1, 100, 0);
    send_frame(8'h3C, DIV, 0, 0, f3c); put(1'b1, 60, 0);

    // Randomized frames: data, bit-length mismatch, gaps, ready pattern, occasional bad stop
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      bl = DIV - 8 + $urandom_range(0, 16);
      sl = ($urandom_range(0, 5) == 0) ? (bl + $urandom_range(10, 400)) : 0;
      send_frame(rb, bl, sl, 2, fr);
      put(1'b1, $urandom_range(0, 60), 2);
    end
    put(1'b1, 200, 2);
    ncyc = wp;

    build_model();

    // Hand-computed points
    add_lit(2, 0, 0, "reset_valid");
    add_lit(3, 1, 8'h00, "reset_data");
    add_lit(fa + 2 + STOPO - 1, 0, 0, "a5_valid_before_stop");
    add_lit(fa + 2 + STOPO, 0, 1, "a5_valid");
    add_lit(fa + 2 + STOPO, 1, 8'hA5, "a5_data");
    add_lit(fa + 2 + STOPO, 2, 0, "a5_no_ferr");
    add_lit(fa + 2 + STOPO, 3, 0, "a5_no_ovr");
    add_lit(rp0, 0, 0, "a5_accept");
    add_lit(fg + 2 + HALF + 5, 0, 0, "glitch_no_valid");
    add_lit(fc + 2 + STOPO, 2, 1, "ferr_pulse");
    add_lit(fc + 2 + STOPO + 1, 2, 0, "ferr_one_cycle");
    add_lit(fc + 2 + STOPO, 0, 0, "ferr_no_valid");
    add_lit(f22 + 2 + STOPO, 3, 1, "overrun_pulse");
    add_lit(f22 + 2 + STOPO, 1, 8'h11, "overrun_keeps_11");
    add_lit(f22 + 2 + STOPO + 1, 3, 0, "overrun_one_cycle");
    add_lit(rp1 - 1, 0, 1, "held_before_accept");
    add_lit(rp1, 0, 0, "accept_clears");
    add_lit(f00 + 2 + STOPO, 1, 8'h00, "stream_00");
    add_lit(fff + 2 + STOPO, 1, 8'hFF, "stream_ff");
    add_lit(f55 + 2 + STOPO, 0, 1, "stream_55_valid");
    add_lit(f55 + 2 + STOPO, 1, 8'h55, "stream_55_data");
    add_lit(f55 + 2 + STOPO + 1, 0, 0, "stream_55_taken");
    add_lit(f3c + 2 + STOPO, 0, 1, "after_reset_valid");
    add_lit(f3c + 2 + STOPO, 1, 8'h3C, "after_reset_data");

    // Pin the model itself at two known points
    checks++;
    if (expo[fa + 2 + STOPO] !== {1'b1, 8'hA5, 2'b00}) begin
      errors++;
      $display("FAIL model_a5: model %03h, required %03h", expo[fa + 2 + STOPO], {1'b1, 8'hA5, 2'b00});
    end
    checks++;
    if (expo[f22 + 2 + STOPO] !== {1'b1, 8'h11, 2'b01}) begin
      errors++;
      $display("FAIL model_overrun: model %03h, required %03h", expo[f22 + 2 + STOPO], {1'b1, 8'h11, 2'b01});
    end

    // Drive and compare every cycle
    for (int e = 0; e < ncyc; e++) begin
      reset_n  = ~rst[e];
      uart_rxd = pin[e];
      ready    = rdy[e];
      if (e > 0 && rst[e] && !rst[e-1]) begin
        #1;
        checks++;
        if ({valid, data, frame_err, overrun} !== 11'd0) begin
          errors++;
          $display("FAIL async_reset cyc %0d: got valid=%0b data=%02h frame_err=%0b overrun=%0b, required all 0",
                   e, valid, data, frame_err, overrun);
        end
      end
      @(posedge clk);
      @(negedge clk);
      got = {valid, data, frame_err, overrun};
      checks++;
      if (got !== expo[e]) begin
        errors++;
        $display("FAIL cycle_compare cyc %0d: got valid=%0b data=%02h frame_err=%0b overrun=%0b, required valid=%0b data=%02h frame_err=%0b overrun=%0b",
                 e, got[10], got[9:2], got[1], got[0], expo[e][10], expo[e][9:2], expo[e][1], expo[e][0]);
      end
      foreach (lits[i]) begin
        if (lits[i].e == e) begin
          case (lits[i].fld)
            0:       gv = int'(valid);
            1:       gv = int'(data);
            2:       gv = int'(frame_err);
            default: gv = int'(overrun);
          endcase
          checks++;
          if (gv != lits[i].val) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0h, required %0h", lits[i].name, e, gv, lits[i].val);
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
